// File: rtl/fod_pkg.sv
// Shared widths, FSM state type and phase arithmetic for the FOD phase tracker.
package fod_pkg;

  localparam int WI = 6;
  localparam int WF = 16;
  localparam int PW = 3 + WF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEED  = 2'd1,
    TRACK = 2'd2
  } fod_state_e;

  // Phase add/subtract; the result drops the carry, so it wraps modulo one
  // full turn of eight aux phases.
  function automatic logic [PW-1:0] phase_wrap(input logic [PW-1:0] a,
                                               input logic [PW-1:0] b,
                                               input logic          sub);
    return sub ? (a - b) : (a + b);
  endfunction

endpackage

// File: rtl/fod_therm_decode.sv
// Registered sampler-word decoder: one valid 1->0 transition gives a phase code,
// anything else is a bubble and the previous code is held.
module fod_therm_decode
  import fod_pkg::*;
(
  input  logic       CLK,
  input  logic       ARST,
  input  logic [7:0] psamp,
  output logic [2:0] phe,
  output logic       phe_vld,
  output logic       bub_err
);

  logic [7:0] psamp_p0;
  logic [7:0] hits;
  logic [2:0] code;
  logic       one_hot;

  // Stage p0: capture the raw sampler word.
  always_ff @(posedge CLK or posedge ARST) begin
    if (ARST) psamp_p0 <= '0;
    else      psamp_p0 <= psamp;
  end

  // Find every phase k whose sample is 1 and whose successor is 0.
  always_comb begin
    hits = '0;
    code = '0;
    for (int k = 0; k < 8; k++) begin
      hits[k] = psamp_p0[k] & ~psamp_p0[(k + 1) % 8];
    end
    for (int k = 0; k < 8; k++) begin
      if (hits[k]) code = 3'(k);
    end
    one_hot = (hits != 8'd0) && ((hits & (hits - 8'd1)) == 8'd0);
  end

  // Stage p1: publish the decoded code; a bubble holds the last good code.
  always_ff @(posedge CLK or posedge ARST) begin
    if (ARST) begin
      phe     <= '0;
      phe_vld <= 1'b0;
      bub_err <= 1'b0;
    end else begin
      phe_vld <= one_hot;
      bub_err <= ~one_hot;
      if (one_hot) phe <= code;
    end
  end

endmodule

// File: rtl/fod_phe_tracker.sv
// FOD phase-error tracker: compares decoded sampler phase against the phase
// predicted from FCW_FOD, integrates the error per window and derives LOCK.
module fod_phe_tracker
  import fod_pkg::*;
#(
  parameter int KSH     = 2,
  parameter int NWIN    = 256,
  parameter int WACC    = 27,
  parameter int LOCK_TH = 2 << WF
) (
  input  logic                   CLK,
  input  logic                   ARST,
  input  logic                   EN,
  input  logic [WI+WF-1:0]       FCW_FOD,
  input  logic [7:0]             PSAMP,
  output logic [2:0]             PHE,
  output logic                   PHE_VLD,
  output logic                   BUB_ERR,
  output logic signed [PW-1:0]   PERR,
  output logic signed [WACC-1:0] ERR_ACC,
  output logic                   ACC_VLD,
  output logic                   LOCK
);

  localparam int CW = $clog2(NWIN);
  localparam logic [WACC:0] LOCK_TH_W = (WACC + 1)'(LOCK_TH);

  // Add a phase error into the window sum, clamping at the signed limits.
  function automatic logic signed [WACC-1:0] sat_add(input logic signed [WACC-1:0] a,
                                                     input logic signed [PW-1:0]   b);
    logic [WACC:0] s;
    s = {a[WACC-1], a} + {{(WACC + 1 - PW){b[PW-1]}}, b};
    if (s[WACC] != s[WACC-1]) begin
      return s[WACC] ? {1'b1, {(WACC - 1){1'b0}}} : {1'b0, {(WACC - 1){1'b1}}};
    end
    return s[WACC-1:0];
  endfunction

  // Magnitude with one extra bit so the most negative sum is representable.
  function automatic logic [WACC:0] abs_val(input logic signed [WACC-1:0] v);
    return v[WACC-1] ? (~{v[WACC-1], v} + 1'b1) : {1'b0, v};
  endfunction

  fod_state_e state, state_nxt;
  logic                   seed, track, clr;
  logic [PW-1:0]          inc_p0;
  logic [PW-1:0]          exp_ph;
  logic [PW-1:0]          phe_word;
  logic signed [PW-1:0]   perr_p2;
  logic                   vld_p2;
  logic signed [WACC-1:0] acc;
  logic signed [WACC-1:0] acc_sum;
  logic [CW-1:0]          cnt;
  logic signed [WACC-1:0] err_acc_p3;
  logic                   acc_vld_p3;
  logic                   lock_p3;
  logic                   pass;
  logic                   pass_prev;
  logic                   unused_fcw_hi;

  // Only the low bits of FCW_FOD survive the modulo-one-turn phase increment.
  assign unused_fcw_hi = ^FCW_FOD[WI+WF-1:PW-KSH];

  fod_therm_decode u_decode (
    .CLK     (CLK),
    .ARST    (ARST),
    .psamp   (PSAMP),
    .phe     (PHE),
    .phe_vld (PHE_VLD),
    .bub_err (BUB_ERR)
  );

  assign phe_word = {PHE, {WF{1'b0}}};
  assign acc_sum  = sat_add(acc, perr_p2);
  assign pass     = (abs_val(acc_sum) <= LOCK_TH_W);
  assign clr      = ~EN || (state == IDLE);

  assign PERR    = perr_p2;
  assign ERR_ACC = err_acc_p3;
  assign ACC_VLD = acc_vld_p3;
  assign LOCK    = lock_p3;

  // FSM state register.
  always_ff @(posedge CLK or posedge ARST) begin
    if (ARST) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; dropping EN overrides everything and returns to IDLE.
  always_comb begin
    state_nxt = state;
    seed      = 1'b0;
    track     = 1'b0;
    case (state)
      IDLE:    if (EN) state_nxt = SEED;
      SEED:    if (PHE_VLD) begin
                 state_nxt = TRACK;
                 seed      = 1'b1;
               end
      TRACK:   track = 1'b1;
      default: state_nxt = IDLE;
    endcase
    if (!EN) begin
      state_nxt = IDLE;
      seed      = 1'b0;
      track     = 1'b0;
    end
  end

  // Stage p0: resample the per-edge phase increment from FCW_FOD.
  always_ff @(posedge CLK or posedge ARST) begin
    if (ARST) inc_p0 <= '0;
    else      inc_p0 <= {FCW_FOD[PW-KSH-1:0], {KSH{1'b0}}};
  end

  // Stage p2: expected-phase predictor and phase error; EXP advances on every
  // tracking edge, bubble or not, so a missed sample never skews the model.
  always_ff @(posedge CLK or posedge ARST) begin
    if (ARST) begin
      exp_ph  <= '0;
      perr_p2 <= '0;
      vld_p2  <= 1'b0;
    end else if (clr) begin
      exp_ph  <= '0;
      perr_p2 <= '0;
      vld_p2  <= 1'b0;
    end else begin
      vld_p2 <= track & PHE_VLD;
      if (seed) begin
        exp_ph <= phase_wrap(phe_word, inc_p0, 1'b0);
      end else if (track) begin
        exp_ph <= phase_wrap(exp_ph, inc_p0, 1'b0);
        if (PHE_VLD) perr_p2 <= $signed(phase_wrap(phe_word, exp_ph, 1'b1));
      end
    end
  end

  // Stage p3: window integrator, window dump and lock qualification.
  always_ff @(posedge CLK or posedge ARST) begin
    if (ARST) begin
      acc        <= '0;
      cnt        <= '0;
      err_acc_p3 <= '0;
      acc_vld_p3 <= 1'b0;
      lock_p3    <= 1'b0;
      pass_prev  <= 1'b0;
    end else if (clr) begin
      acc        <= '0;
      cnt        <= '0;
      err_acc_p3 <= '0;
      acc_vld_p3 <= 1'b0;
      lock_p3    <= 1'b0;
      pass_prev  <= 1'b0;
    end else begin
      acc_vld_p3 <= 1'b0;
      if (vld_p2) begin
        if (cnt == CW'(NWIN - 1)) begin
          err_acc_p3 <= acc_sum;
          acc_vld_p3 <= 1'b1;
          acc        <= '0;
          cnt        <= '0;
          lock_p3    <= pass & pass_prev;
          pass_prev  <= pass;
        end else begin
          acc <= acc_sum;
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fod_phe_tracker.sv
// Directed bench for fod_phe_tracker: decode, bubbles, tracking, lock, EN and ARST.
module tb_fod_phe_tracker;
  import fod_pkg::*;

  logic                 CLK;
  logic                 ARST;
  logic                 EN;
  logic [WI+WF-1:0]     FCW_FOD;
  logic [7:0]           PSAMP;
  logic [2:0]           PHE;
  logic                 PHE_VLD;
  logic                 BUB_ERR;
  logic signed [PW-1:0] PERR;
  logic signed [26:0]   ERR_ACC;
  logic                 ACC_VLD;
  logic                 LOCK;

  int n_cmp = 0;
  int n_err = 0;
  int ph    = 0;
  int n;
  int k_first;

  fod_phe_tracker dut (
    .CLK     (CLK),
    .ARST    (ARST),
    .EN      (EN),
    .FCW_FOD (FCW_FOD),
    .PSAMP   (PSAMP),
    .PHE     (PHE),
    .PHE_VLD (PHE_VLD),
    .BUB_ERR (BUB_ERR),
    .PERR    (PERR),
    .ERR_ACC (ERR_ACC),
    .ACC_VLD (ACC_VLD),
    .LOCK    (LOCK)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [7:0] therm(input int p);
    logic [7:0] w;
    w = '0;
    for (int j = 0; j < 4; j++) w[(p - j + 8) % 8] = 1'b1;
    return w;
  endfunction

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick_raw(input logic [7:0] w);
    PSAMP = w;
    @(posedge CLK);
    #1;
  endtask

  task automatic tick_ph(input int step);
    ph = (ph + step) % 8;
    tick_raw(therm(ph));
  endtask

  task automatic tick_bub(input int step);
    ph = (ph + step) % 8;
    tick_raw(8'h00);
  endtask

  // Drive a phase stream until ACC_VLD or the cycle budget runs out.
  task automatic wait_win(input int step, output int cnt_o);
    cnt_o = 0;
    do begin
      tick_ph(step);
      cnt_o++;
    end while (!ACC_VLD && cnt_o < 400);
    chk("acc_vld_seen", longint'(ACC_VLD), 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_phe"},     longint'(PHE), 0);
    chk({tag, "_phe_vld"}, longint'(PHE_VLD), 0);
    chk({tag, "_bub_err"}, longint'(BUB_ERR), 0);
    chk({tag, "_perr"},    longint'(PERR), 0);
    chk({tag, "_err_acc"}, longint'(ERR_ACC), 0);
    chk({tag, "_acc_vld"}, longint'(ACC_VLD), 0);
    chk({tag, "_lock"},    longint'(LOCK), 0);
  endtask

  initial begin
    ARST    = 1'b1;
    EN      = 1'b0;
    FCW_FOD = 22'(17 * 16384);   // 4.25 in Q6.16 -> one aux phase per edge
    PSAMP   = 8'h00;
    #12;
    chk_all_zero("reset");
    ARST = 1'b0;
    #3;

    // Decode sweep and bubbles, tracker disabled.
    tick_raw(8'b0000_1111);
    tick_raw(8'b1100_0011);
    chk("dec_0f_phe", longint'(PHE), 3);
    chk("dec_0f_vld", longint'(PHE_VLD), 1);
    tick_raw(8'b1000_0111);
    chk("dec_c3_phe", longint'(PHE), 1);
    chk("dec_c3_vld", longint'(PHE_VLD), 1);
    tick_raw(8'h00);
    chk("dec_87_phe", longint'(PHE), 2);
    chk("dec_87_bub", longint'(BUB_ERR), 0);
    tick_raw(8'hFF);
    chk("bub_00_bub", longint'(BUB_ERR), 1);
    chk("bub_00_phe", longint'(PHE), 2);
    tick_raw(8'b0101_0101);
    chk("bub_ff_bub", longint'(BUB_ERR), 1);
    chk("bub_ff_phe", longint'(PHE), 2);
    tick_raw(8'b0000_1111);
    chk("bub_55_bub", longint'(BUB_ERR), 1);
    chk("bub_55_vld", longint'(PHE_VLD), 0);
    chk("bub_55_phe", longint'(PHE), 2);

    // Ideal tracking: two clean windows give lock on the second.
    ph = 0;
    for (int i = 0; i < 3; i++) tick_ph(1);
    EN = 1'b1;
    for (int i = 0; i < 100; i++) tick_ph(1);
    chk("ideal_perr", longint'(PERR), 0);
    wait_win(1, n);
    chk("ideal_w1_acc", longint'(ERR_ACC), 0);
    chk("ideal_w1_lock", longint'(LOCK), 0);
    wait_win(1, n);
    chk("ideal_w2_len", longint'(n), 256);
    chk("ideal_w2_acc", longint'(ERR_ACC), 0);
    chk("ideal_w2_lock", longint'(LOCK), 1);

    // EN drop while locked clears on the next edge; relock needs two windows.
    tick_ph(1);
    EN = 1'b0;
    tick_ph(1);
    chk("en_off_lock", longint'(LOCK), 0);
    chk("en_off_perr", longint'(PERR), 0);
    tick_ph(1);
    EN = 1'b1;
    wait_win(1, n);
    chk("reen_w1_acc", longint'(ERR_ACC), 0);
    chk("reen_w1_lock", longint'(LOCK), 0);
    wait_win(1, n);
    chk("reen_w2_acc", longint'(ERR_ACC), 0);
    chk("reen_w2_lock", longint'(LOCK), 1);

    // Step of two phases per sample against a one-phase prediction.
    tick_ph(2);
    tick_ph(2);
    tick_ph(2);
    chk("off_perr_p1", longint'(PERR), 65536);
    tick_ph(2);
    chk("off_perr_p2", longint'(PERR), 2 * 65536);
    tick_ph(2);
    chk("off_perr_p3", longint'(PERR), 3 * 65536);
    tick_ph(2);
    chk("off_perr_m4", longint'(PERR), -4 * 65536);
    tick_ph(2);
    chk("off_perr_m3", longint'(PERR), -3 * 65536);
    wait_win(2, n);
    chk("off_w_acc", longint'(ERR_ACC), -125 * 65536);
    chk("off_w_lock", longint'(LOCK), 0);

    // Asynchronous reset mid-window, then a fresh seed and a full window.
    for (int i = 0; i < 100; i++) tick_ph(1);
    #2;
    ARST = 1'b1;
    #1;
    chk_all_zero("arst");
    #1;
    ARST = 1'b0;
    k_first = 0;
    for (int i = 1; i <= 300 && k_first == 0; i++) begin
      if (i >= 50 && i <= 53) tick_bub(1);
      else                    tick_ph(1);
      if (ACC_VLD) k_first = i;
    end
    chk("arst_win_edge", longint'(k_first), 264);
    chk("arst_win_acc", longint'(ERR_ACC), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
